// File: rtl/regfile_multiport.sv
// Multi-port MIPS register file: NUM_RD registered read ports, one write port.
// Optional REGFILE_BYPASS_EN forwards a same-edge write to matching reads.
module regfile_multiport #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_valid
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] regs   [DEPTH];
  logic [ADDR_W-1:0] addr   [NUM_RD];
  logic [DATA_W-1:0] rd_nxt [NUM_RD];
  logic [DATA_W-1:0] data_q [NUM_RD];
  logic [NUM_RD-1:0] valid_q;
  logic              wr_hit;

  assign wr_hit = wr_en && (wr_addr != '0);

  genvar g;
  generate
    for (g = 0; g < NUM_RD; g++) begin : g_port
      assign addr[g] = rd_addr[g*ADDR_W +: ADDR_W];
      assign rd_data[g*DATA_W +: DATA_W] = data_q[g];
    end
  endgenerate

  assign rd_valid = valid_q;

  // r0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs <= '{default: '0};
    end else if (wr_hit) begin
      regs[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_RD; i++) begin
      rd_nxt[i] = regs[addr[i]];
      if (addr[i] == '0) begin
        rd_nxt[i] = '0;
      end
`ifdef REGFILE_BYPASS_EN
      else if (wr_hit && (wr_addr == addr[i])) begin
        rd_nxt[i] = wr_data;
      end
`endif
    end
  end

  // Idle ports keep their last data; only the valid strobe drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '{default: '0};
      valid_q <= '0;
    end else begin
      for (int i = 0; i < NUM_RD; i++) begin
        valid_q[i] <= rd_en[i];
        if (rd_en[i]) begin
          data_q[i] <= rd_nxt[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_multiport.sv
// Directed bench for regfile_multiport with a 3-port scoreboard.
// Honours REGFILE_BYPASS_EN when computing same-edge hazard results.
module tb_regfile_multiport;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 3;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [DW-1:0]    wr_data;
  logic [NR-1:0]    rd_en;
  logic [NR*AW-1:0] rd_addr;
  logic [NR*DW-1:0] rd_data;
  logic [NR-1:0]    rd_valid;

  regfile_multiport #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_valid (rd_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic        v;
    logic [31:0] d;
  } exp_t;

  exp_t        sb [$];
  logic [31:0] model [32];
  logic [31:0] held  [NR];
  int          total = 0;
  int          bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 32; i++) model[i] = '0;
    for (int i = 0; i < NR; i++) held[i] = '0;
  endtask

  task automatic chk_reset(input string tag);
    for (int i = 0; i < NR; i++) begin
      chk($sformatf("%s.v%0d", tag, i), 32'(rd_valid[i]), 32'd0);
      chk($sformatf("%s.d%0d", tag, i), rd_data[i*DW +: DW], 32'd0);
    end
  endtask

  task automatic cycle(input string tag, input logic we,
                       input logic [4:0] wa, input logic [31:0] wd,
                       input logic [2:0] ren, input logic [4:0] a0,
                       input logic [4:0] a1, input logic [4:0] a2);
    logic [4:0] ra [NR];
    exp_t       e;
    ra = '{a0, a1, a2};
    wr_en   = we;
    wr_addr = wa;
    wr_data = wd;
    rd_en   = ren;
    rd_addr = {a2, a1, a0};
    for (int i = 0; i < NR; i++) begin
      if (ren[i]) begin
        if (ra[i] == 5'd0) held[i] = '0;
        else if (BYP && we && wa == ra[i]) held[i] = wd;
        else held[i] = model[ra[i]];
      end
      e.tag = $sformatf("%s.p%0d", tag, i);
      e.v   = ren[i];
      e.d   = held[i];
      sb.push_back(e);
    end
    if (we && wa != 5'd0) model[wa] = wd;
    @(posedge clk);
    #1;
    for (int i = 0; i < NR; i++) begin
      e = sb.pop_front();
      chk({e.tag, ".valid"}, 32'(rd_valid[i]), 32'(e.v));
      chk({e.tag, ".data"}, rd_data[i*DW +: DW], e.d);
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    rd_en   = '0;
    rd_addr = '0;
    clear_model();
    #12;
    chk_reset("por");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // basic write then read
    cycle("t2w", 1, 5'd3, 32'h12345678, 3'b000, 0, 0, 0);
    cycle("t2r", 0, 5'd0, 32'h0, 3'b001, 5'd3, 0, 0);

    // asynchronous reset mid-stream
    cycle("t1w", 1, 5'd5, 32'hDEADBEEF, 3'b000, 0, 0, 0);
    cycle("t1r", 0, 5'd0, 32'h0, 3'b111, 5'd5, 5'd5, 5'd3);
    wr_en   = 1'b1;
    wr_addr = 5'd5;
    wr_data = 32'h0BAD0BAD;
    rd_en   = 3'b111;
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset("t1async");
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    chk_reset("t1hold");
    wr_en = 1'b0;
    rd_en = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cycle("t1post", 0, 5'd0, 32'h0, 3'b111, 5'd5, 5'd3, 5'd5);

    // r0 is hardwired
    cycle("t3w", 1, 5'd0, 32'hFFFFFFFF, 3'b000, 0, 0, 0);
    cycle("t3r", 0, 5'd0, 32'h0, 3'b111, 0, 0, 0);

    // same-edge write/read hazard
    cycle("t4a", 1, 5'd7, 32'h11, 3'b000, 0, 0, 0);
    cycle("t4b", 1, 5'd7, 32'h22, 3'b011, 5'd7, 5'd7, 0);
    cycle("t4c", 0, 5'd0, 32'h0, 3'b010, 0, 5'd7, 0);
    cycle("t4z", 1, 5'd0, 32'h33, 3'b001, 5'd0, 0, 0);

    // multiport and hold
    cycle("t5a", 1, 5'd1, 32'hA, 3'b000, 0, 0, 0);
    cycle("t5b", 1, 5'd31, 32'hB, 3'b000, 0, 0, 0);
    cycle("t5c", 0, 5'd0, 32'h0, 3'b111, 5'd1, 5'd1, 5'd31);
    cycle("t5d", 0, 5'd0, 32'h0, 3'b101, 5'd1, 5'd31, 5'd31);

    // full sweep on rotating ports
    for (int k = 1; k < 32; k++) begin
      cycle($sformatf("t6w%0d", k), 1, 5'(k), 32'(k) * 32'h01010101,
            3'b000, 0, 0, 0);
    end
    for (int k = 0; k < 32; k++) begin
      cycle($sformatf("t6r%0d", k), 0, 5'd0, 32'h0,
            3'(1 << (k % 3)), 5'(k), 5'(k), 5'(k));
    end
    cycle("t6all", 0, 5'd0, 32'h0, 3'b111, 5'd0, 5'd17, 5'd31);

    wr_en = 1'b0;
    rd_en = '0;
    total++;
    assert (sb.size() == 0) else begin
      bad++;
      $error("FAIL sb_drain observed=%0d expected=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
